// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: datapath width, bus word type and the controller word layout.
package sap1_pkg;

    localparam int unsigned SAP1_WIDTH = 8;

    typedef logic [SAP1_WIDTH-1:0] word_t;

    // Controller strobes in the same field order the controller emits them.
    typedef struct packed {
        logic c_p;
        logic e_p;
        logic l_m_n;
        logic c_e_n;
        logic l_i_n;
        logic e_i_n;
        logic l_a_n;
        logic e_a;
        logic s_u;
        logic e_u;
        logic l_b_n;
        logic l_o_n;
    } ctrl_word_t;

endpackage : sap1_pkg

// File: rtl/acc_breg_if.sv
// W-bus / adder-facing connection bundle for the accumulator and B register.
// Optional flag outputs appear when ACC_FLAGS_EN is defined.
interface acc_breg_if
    import sap1_pkg::*;
#(
    parameter int unsigned WIDTH = SAP1_WIDTH
);
    logic [WIDTH-1:0] W_BUS_IN;
    logic             L_A_N;
    logic             E_A;
    logic             L_B_N;
    logic [WIDTH-1:0] ACC_Q;
    logic [WIDTH-1:0] B_Q;
    logic [WIDTH-1:0] W_BUS_OUT;
    logic             W_BUS_OE;
    logic             LOAD_CONFLICT;
`ifdef ACC_FLAGS_EN
    logic             ZERO_F;
    logic             SIGN_F;
`endif

    // Controller / bus-mux side.
    modport master (
        output W_BUS_IN, L_A_N, E_A, L_B_N,
        input  ACC_Q, B_Q, W_BUS_OUT, W_BUS_OE, LOAD_CONFLICT
`ifdef ACC_FLAGS_EN
        , input ZERO_F, SIGN_F
`endif
    );

    // Register block side.
    modport slave (
        input  W_BUS_IN, L_A_N, E_A, L_B_N,
        output ACC_Q, B_Q, W_BUS_OUT, W_BUS_OE, LOAD_CONFLICT
`ifdef ACC_FLAGS_EN
        , output ZERO_F, SIGN_F
`endif
    );

endinterface : acc_breg_if

// File: rtl/acc_breg_reg_ld.sv
// Generic register with async active-low clear and active-low synchronous load.
module reg_ld #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ld_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d when the load strobe is low, otherwise hold.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q <= '0;
        end else if (!ld_n) begin
            q <= d;
        end
    end

endmodule : reg_ld

// File: rtl/acc_breg.sv
// SAP-1 accumulator (A) and B register feeding the adder-subtractor.
// Optional macro ACC_FLAGS_EN adds registered ZERO_F / SIGN_F outputs.
module acc_breg
    import sap1_pkg::*;
#(
    parameter int unsigned WIDTH = SAP1_WIDTH
) (
    input  logic        CLK,
    input  logic        CLR_N,
    acc_breg_if.slave   bus
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] b_q;
    logic             conflict_q;

    reg_ld #(.WIDTH(WIDTH)) u_acc (
        .clk   (CLK),
        .clr_n (CLR_N),
        .ld_n  (bus.L_A_N),
        .d     (bus.W_BUS_IN),
        .q     (acc_q)
    );

    reg_ld #(.WIDTH(WIDTH)) u_breg (
        .clk   (CLK),
        .clr_n (CLR_N),
        .ld_n  (bus.L_B_N),
        .d     (bus.W_BUS_IN),
        .q     (b_q)
    );

    // Sticky debug flag: accumulator loading while it is also driving the bus.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            conflict_q <= 1'b0;
        end else if (!bus.L_A_N && bus.E_A) begin
            conflict_q <= 1'b1;
        end
    end

`ifdef ACC_FLAGS_EN
    logic zero_q;
    logic sign_q;

    // Flags computed from the incoming load value so they line up with ACC_Q.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            zero_q <= 1'b0;
            sign_q <= 1'b0;
        end else if (!bus.L_A_N) begin
            zero_q <= (bus.W_BUS_IN == '0);
            sign_q <= bus.W_BUS_IN[WIDTH-1];
        end
    end

    assign bus.ZERO_F = zero_q;
    assign bus.SIGN_F = sign_q;
`endif

    // Bus source is zero when idle so the bus mux can OR all sources.
    assign bus.W_BUS_OE      = bus.E_A;
    assign bus.W_BUS_OUT     = bus.E_A ? acc_q : '0;
    assign bus.ACC_Q         = acc_q;
    assign bus.B_Q           = b_q;
    assign bus.LOAD_CONFLICT = conflict_q;

endmodule : acc_breg

// File: doc/acc_breg.md
Name: acc_breg

Overview:
- SAP-1 accumulator (A) and B register pair; the stage directly upstream of the adder-subtractor.
- Loads operands from the W-bus under controller strobes and presents them continuously to the adder-subtractor A/B inputs.
- The adder-subtractor result returns via the W-bus and is captured back into the accumulator.
- Also drives accumulator contents onto the W-bus for OUT/STA-style transfers.

Parameters:
WIDTH, 8, data width of both registers and the bus.

Ports:
CLK  input  1  system clock; all state updates on the rising edge
CLR_N  input  1  asynchronous active-low reset
W_BUS_IN  input  WIDTH  current W-bus value (resolved bus, from the bus mux)
L_A_N  input  1  accumulator load strobe, active-low
E_A  input  1  accumulator bus-drive enable, active-high
L_B_N  input  1  B register load strobe, active-low
ACC_Q  output  WIDTH  accumulator contents, to adder-subtractor A
B_Q  output  WIDTH  B register contents, to adder-subtractor B
W_BUS_OUT  output  WIDTH  accumulator value for the bus mux; zero when not driving
W_BUS_OE  output  1  bus-drive request, equals E_A
LOAD_CONFLICT  output  1  registered flag: L_A_N low and E_A high sampled on the same edge

Behaviour:
- Reset: CLR_N low asynchronously clears ACC_Q, B_Q and LOAD_CONFLICT to 0.
  - Held low: registers stay 0 and strobes are ignored.
  - Deassertion is synchronised by the environment; the block needs no internal release logic.
- Accumulator:
  - Rising CLK with L_A_N=0 loads W_BUS_IN.
  - Otherwise holds.
  - One-cycle latency: the new value is visible on ACC_Q after the edge.
- B register: rising CLK with L_B_N=0 loads W_BUS_IN; otherwise holds.
- Simultaneous L_A_N=0 and L_B_N=0: both registers load the same W_BUS_IN value. This is legal.
- Bus drive is combinational:
  - W_BUS_OE = E_A.
  - W_BUS_OUT = ACC_Q when E_A=1, else all zeros, so the bus mux can OR sources.
  - No internal tri-states.
- Conflict (L_A_N=0 and E_A=1 on the same edge):
  - Accumulator still loads W_BUS_IN, which is the bus-resolved value.
  - LOAD_CONFLICT goes to 1 on that edge and stays sticky until CLR_N.
  - The flag is a debug aid only and has no functional effect.
- Widths: WIDTH bits, no sign extension, no arithmetic inside this block. Wrap-around belongs to the adder-subtractor.
- Accumulate loop (ADD/SUB):
  - Controller asserts E_U (outside this block), which puts the sum on the bus.
  - L_A_N=0 on the same edge captures the sum.
  - ACC_Q then updates, so the adder-subtractor's S changes in the following cycle. No combinational loop exists inside this block.
- Reset mid-operation: CLR_N low at any phase aborts the transfer. Registers clear immediately without waiting for CLK.

Optional Feature:
- Macro: ACC_FLAGS_EN.
- When defined, two extra outputs are present:
  - ZERO_F = 1 when the accumulator value is all zeros.
  - SIGN_F = MSB of the accumulator.
- Both flags are registered: updated on every edge where L_A_N=0, using W_BUS_IN (the value being loaded), so they track ACC_Q with no extra latency.
- Both flags are held otherwise.
- Both reset to 0 with CLR_N low; because the flags are 0 after reset, ZERO_F is 0 after reset, not 1.
- When undefined, the ports and logic are absent and all other behaviour is identical.

Decomposition:
- Shared package sap1_pkg:
  - constant SAP1_WIDTH = 8.
  - typedef word_t as logic [SAP1_WIDTH-1:0].
  - typedef packed struct ctrl_word_t holding the SAP-1 control bits (C_P, E_P, L_M_N, C_E_N, L_I_N, E_I_N, L_A_N, E_A, S_U, E_U, L_B_N, L_O_N). The controller and this block share the same field order.
- One sub-module: reg_ld. A WIDTH-bit register with async active-low clear and active-low load, instantiated twice (accumulator, B register).

Test Plan:
- Reset: drive W_BUS_IN=8'hA5 with L_A_N=0 and L_B_N=0 while CLR_N=0 for 3 cycles -> ACC_Q=0, B_Q=0, LOAD_CONFLICT=0 throughout.
- Load A and B:
  - Cycle 1: W_BUS_IN=8'h07, L_A_N=0 -> ACC_Q=8'h07 after the edge.
  - Cycle 2: W_BUS_IN=8'h03, L_B_N=0 -> B_Q=8'h03, ACC_Q stays 8'h07.
  - With all strobes high for 5 cycles, both registers hold.
- Bus drive: ACC_Q=8'h3C.
  - E_A=1 -> W_BUS_OE=1, W_BUS_OUT=8'h3C in the same cycle.
  - E_A=0 -> W_BUS_OUT=8'h00, W_BUS_OE=0.
- Accumulate loop with an external adder-subtractor model: ACC_Q=8'hFE, B_Q=8'h03.
  - Add: bus=sum, L_A_N=0 -> ACC_Q=8'h01 (wrap).
  - Then S_U=1 subtract: ACC_Q=8'hFE.
- Conflict and async reset:
  - L_A_N=0 with E_A=1 and W_BUS_IN=8'h55 -> ACC_Q=8'h55, LOAD_CONFLICT=1, which remains 1 after the strobes are removed.
  - CLR_N pulsed low mid-cycle (no clock edge) -> immediate 0 on all outputs.
- With ACC_FLAGS_EN:
  - Load 8'h80 -> SIGN_F=1, ZERO_F=0.
  - Load 8'h00 -> ZERO_F=1, SIGN_F=0.
  - Strobes idle -> flags hold.
